seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the washer's multi-digit 7-seg display.
//  Latches BCD digits (remaining wash time, mm:ss) from the control FSM and
//  drives one digit at a time: num[3:0] goes to the 7-seg decoder, digit_sel to
//  the common-anode enables. Provides tear-free update, leading-zero blanking
//  and anti-ghost blanking between digit slots.
// PARAMETERS
//  DIGITS     4       number of display digits (2..8)
//  SCAN_DIV   50000   clk cycles per digit slot (1 kHz slot rate @ 50 MHz)
//  BLANK_CYC  64      cycles at start of each slot with all digits off (< SCAN_DIV)
//  BLINK_DIV  25000000 half-period of blink in clk cycles (BLINK_EN builds only)
// PORTS
//  clk        in   1          system clock
//  rst_n      in   1          reset; asynchronous, active-low
//  upd        in   1          1-cycle strobe: capture bcd_in into shadow register
//  bcd_in     in   4*DIGITS   digit i = bcd_in[4i+3:4i]; digit 0 = rightmost
//  lzb_en     in   1          1 = blank leading zeros
//  upd_pend   out  1          shadow holds data not yet shown
//  num        out  4          digit value to decoder; 4'hF = dark
//  digit_sel  out  DIGITS     active-low digit enable, at most one bit low
//  dp         out  1          active-low decimal point; low on digit 2 only (mm.ss)
//  blink      in   1          (BLINK_EN only) 1 = flash whole display
// BEHAVIOUR
//  Reset: num=4'hF, digit_sel=all 1, dp=1, upd_pend=0; div_cnt=0, idx=0,
//   shadow=0, active=0. Async assert; first scan slot starts 1st clk after release.
//  div_cnt counts 0..SCAN_DIV-1 then wraps; on wrap idx advances, DIGITS-1 -> 0.
//  Outputs registered: num/digit_sel/dp reflect idx and div_cnt of previous cycle
//   (latency 1 clk).
//  Slot: while div_cnt < BLANK_CYC -> digit_sel=all 1, num=4'hF, dp=1; else
//   digit_sel[idx]=0 and num=disp(idx).
//  Update: upd=1 -> shadow<=bcd_in, upd_pend<=1. Shadow->active copy only on the
//   cycle idx wraps DIGITS-1->0 (frame boundary); upd_pend<=0 that cycle.
//   upd on that same cycle: bcd_in goes straight to active, upd_pend stays 0.
//   Repeated upd before boundary: last value wins.
//  disp(i): digit value >9 -> 4'hF. If lzb_en and active digits DIGITS-1..i all
//   zero and i!=0 -> 4'hF. Digit 0 never blanked by LZB. dp follows digit_sel[2]
//   (dp=1 if DIGITS<3).
//  lzb_en sampled combinationally each cycle; change takes effect next output.
//  Reset mid-scan: all state to reset values; pending update discarded.
// CONFIGURATION
//  SEG_SCAN_BLINK_EN defined: blink port and BLINK_DIV present; free-running
//   phase counter toggles every BLINK_DIV cycles; while blink=1 and phase=1,
//   digit_sel=all 1, num=4'hF, dp=1; scan/update logic unaffected; phase resets 0.
//  Not defined: no blink port, no counter; display never flashed.
// TESTING (bench params DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=64)
//  1 reset: rst_n=0 mid-slot -> num=F, digit_sel=1111, dp=1, upd_pend=0 same cycle.
//  2 scan: upd with 16'h1234 at reset -> sel 1110/1101/1011/0111 each 6 cyc lit,
//    2 cyc dark, num 4,3,2,1 after first frame boundary; dp low only on 1011.
//  3 tear-free: upd 16'h5678 while idx=1 -> upd_pend=1, digits 2,3 still old
//    values; at idx wrap shows 8,7,6,5, upd_pend=0.
//  4 LZB: active=16'h0005, lzb_en=1 -> num F,F,F,5; 16'h0000 -> F,F,F,0;
//    lzb_en=0 -> 0,0,0,5; digit 4'hC -> F.
//  5 corner: upd on wrap cycle -> shown next frame, upd_pend never set; two upd
//    before boundary -> only last shown.
//  6 blink (SEG_SCAN_BLINK_EN): blink=1 -> dark 64 cyc / scanning 64 cyc;
//    blink=0 -> continuous scan.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for the washer's multi-digit 7-segment
//   display. BCD digits (remaining wash time, mm:ss) are captured into a shadow
//   register and copied to the displayed (active) register only at a frame
//   boundary, so a digit never changes mid-frame. One digit is driven per slot;
//   each slot begins with a short all-dark gap to suppress ghosting, and
//   leading zeros can optionally be blanked.
//
//   Optional feature macro: SEG_SCAN_BLINK_EN
//     defined   -> blink input and BLINK_DIV parameter exist; a free-running
//                  phase counter darkens the whole display on alternate
//                  BLINK_DIV-cycle half-periods while blink=1.
//     undefined -> no blink port or counter; the display is never flashed.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   upd        1-cycle strobe: capture bcd_in into the shadow register
//   bcd_in     packed BCD digits, digit i = bcd_in[4i+3:4i], digit 0 rightmost
//   lzb_en     1 = blank leading zeros
//   blink      (SEG_SCAN_BLINK_EN only) 1 = flash whole display
//   upd_pend   shadow holds data not yet shown
//   num        digit value to the 7-seg decoder, 4'hF = dark
//   digit_sel  active-low digit enables, at most one bit low
//   dp         active-low decimal point, lit with digit 2 only (mm.ss)
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 50000,
`ifdef SEG_SCAN_BLINK_EN
   parameter int BLINK_DIV = 25000000,
`endif
   parameter int BLANK_CYC = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                upd,
   input  logic [4*DIGITS-1:0] bcd_in,
   input  logic                lzb_en,
`ifdef SEG_SCAN_BLINK_EN
   input  logic                blink,
`endif
   output logic                upd_pend,
   output logic [3:0]          num,
   output logic [DIGITS-1:0]   digit_sel,
   output logic                dp
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = $clog2(DIGITS);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
   localparam logic [IDX_W-1:0] IDX_DP    = IDX_W'(2);

   logic [CNT_W-1:0]    div_cnt;
   logic [IDX_W-1:0]    idx;
   logic [4*DIGITS-1:0] shadow;
   logic [4*DIGITS-1:0] active;

   logic slot_end;
   logic frame_end;

   assign slot_end  = (div_cnt == CNT_LAST);
   assign frame_end = slot_end && (idx == IDX_LAST);

   // Slot timer and digit index.
   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         idx     <= '0;
      end else begin
         div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
         if (slot_end) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end
      end
   end

   // Tear-free update: shadow collects the latest strobe, active changes only
   // at the frame boundary. A strobe on the boundary cycle bypasses the shadow
   // so it is shown in the very next frame and never appears as pending.
   // NOTE: shadow/active are ordinary resettable flops (not a RAM), so they are
   // cleared by reset, which also discards any pending update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow   <= '0;
         active   <= '0;
         upd_pend <= 1'b0;
      end else begin
         if (upd) begin
            shadow <= bcd_in;
         end
         if (frame_end) begin
            upd_pend <= 1'b0;
            if (upd) begin
               active <= bcd_in;
            end else if (upd_pend) begin
               active <= shadow;
            end
         end else if (upd) begin
            upd_pend <= 1'b1;
         end
      end
   end

`ifdef SEG_SCAN_BLINK_EN
   localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);

   logic [BL_W-1:0] blink_cnt;
   logic            phase;

   // Free-running blink phase; runs regardless of the blink input so the
   // flash cadence stays steady when blink is toggled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (blink_cnt == BL_LAST) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end
`endif

   logic [DIGITS-1:0] lead_zero;   // lead_zero[i]: digits DIGITS-1..i all zero
   logic              zero_run;
   logic [3:0]        cur;
   logic [3:0]        num_nxt;
   logic [DIGITS-1:0] sel_nxt;
   logic              dp_nxt;

   // Next-cycle display outputs derived from the current slot position.
   // NOTE: every signal gets a default before any branch so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      lead_zero = '0;
      zero_run  = 1'b1;
      sel_nxt   = '1;
      num_nxt   = 4'hF;
      dp_nxt    = 1'b1;

      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run     = zero_run & (active[4*i +: 4] == 4'd0);
         lead_zero[i] = zero_run;
      end

      cur = active[4*idx +: 4];

      if (div_cnt >= CNT_BLANK) begin
         sel_nxt[idx] = 1'b0;
         if (cur > 4'd9) begin
            num_nxt = 4'hF;
         end else if (lzb_en && (idx != '0) && lead_zero[idx]) begin
            num_nxt = 4'hF;
         end else begin
            num_nxt = cur;
         end
         if ((DIGITS >= 3) && (idx == IDX_DP)) begin
            dp_nxt = 1'b0;
         end
      end

`ifdef SEG_SCAN_BLINK_EN
      if (blink && phase) begin
         sel_nxt = '1;
         num_nxt = 4'hF;
         dp_nxt  = 1'b1;
      end
`endif
   end

   // Registered outputs: one clock behind the slot position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num       <= 4'hF;
         digit_sel <= '1;
         dp        <= 1'b1;
      end else begin
         num       <= num_nxt;
         digit_sel <= sel_nxt;
         dp        <= dp_nxt;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Directed bench for seg_scan_ctrl with DIGITS=4, SCAN_DIV=8, BLANK_CYC=2
//   (BLINK_DIV=64 when SEG_SCAN_BLINK_EN is defined). Expected digits per frame
//   are hand-computed and written as 16-bit words {slot3,slot2,slot1,slot0}.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

   localparam int DIGITS    = 4;
   localparam int SCAN_DIV  = 8;
   localparam int BLANK_CYC = 2;
`ifdef SEG_SCAN_BLINK_EN
   localparam int BLINK_DIV = 64;
`endif

   logic                clk;
   logic                rst_n;
   logic                upd;
   logic [4*DIGITS-1:0] bcd_in;
   logic                lzb_en;
`ifdef SEG_SCAN_BLINK_EN
   logic                blink;
`endif
   logic                upd_pend;
   logic [3:0]          num;
   logic [DIGITS-1:0]   digit_sel;
   logic                dp;

   int checks   = 0;
   int failures = 0;

   seg_scan_ctrl #(
      .DIGITS    (DIGITS),
      .SCAN_DIV  (SCAN_DIV),
`ifdef SEG_SCAN_BLINK_EN
      .BLINK_DIV (BLINK_DIV),
`endif
      .BLANK_CYC (BLANK_CYC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .upd       (upd),
      .bcd_in    (bcd_in),
      .lzb_en    (lzb_en),
`ifdef SEG_SCAN_BLINK_EN
      .blink     (blink),
`endif
      .upd_pend  (upd_pend),
      .num       (num),
      .digit_sel (digit_sel),
      .dp        (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle at the following falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Walk one slot from position 'first'; optionally pulse upd before tick upd_at.
   task automatic run_slot(input int first, input logic [3:0] sel, input logic [3:0] n,
                           input logic dp_exp, input int upd_at, input logic [15:0] upd_val,
                           input string tag);
      for (int c = first; c < SCAN_DIV; c++) begin
         if (c == upd_at) begin
            upd    = 1'b1;
            bcd_in = upd_val;
         end
         tick();
         upd = 1'b0;
         if (c < BLANK_CYC) begin
            chk(32'(digit_sel), 32'hF, $sformatf("%s dark sel c%0d", tag, c));
            chk(32'(num),       32'hF, $sformatf("%s dark num c%0d", tag, c));
            chk(32'(dp),        32'h1, $sformatf("%s dark dp c%0d", tag, c));
         end else begin
            chk(32'(digit_sel), 32'(sel),    $sformatf("%s sel c%0d", tag, c));
            chk(32'(num),       32'(n),      $sformatf("%s num c%0d", tag, c));
            chk(32'(dp),        32'(dp_exp), $sformatf("%s dp c%0d", tag, c));
         end
      end
   endtask

   // One full frame; exp holds the expected num per slot, slot 0 in bits [3:0].
   task automatic run_frame(input logic [15:0] exp, input int upd_slot, input int upd_at,
                            input logic [15:0] upd_val, input string tag);
      logic [3:0] sel;
      for (int s = 0; s < DIGITS; s++) begin
         sel    = 4'b1111;
         sel[s] = 1'b0;
         run_slot(0, sel, exp[4*s +: 4], (s == 2) ? 1'b0 : 1'b1,
                  (s == upd_slot) ? upd_at : -1, upd_val, $sformatf("%s d%0d", tag, s));
         if (s == upd_slot) begin
            chk(32'(upd_pend), (s == DIGITS - 1 && upd_at == SCAN_DIV - 1) ? 32'h0 : 32'h1,
                $sformatf("%s pend after upd", tag));
         end
      end
      chk(32'(upd_pend), 32'h0, $sformatf("%s pend at frame end", tag));
   endtask

`ifdef SEG_SCAN_BLINK_EN
   task automatic run_dark(input int cycles, input string tag);
      for (int c = 0; c < cycles; c++) begin
         tick();
         chk(32'(digit_sel), 32'hF, $sformatf("%s sel c%0d", tag, c));
         chk(32'(num),       32'hF, $sformatf("%s num c%0d", tag, c));
         chk(32'(dp),        32'h1, $sformatf("%s dp c%0d", tag, c));
      end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n  = 1'b0;
      upd    = 1'b0;
      bcd_in = '0;
      lzb_en = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
      blink  = 1'b0;
`endif
      repeat (3) tick();
      chk(32'(num),       32'hF, "reset num");
      chk(32'(digit_sel), 32'hF, "reset sel");
      chk(32'(dp),        32'h1, "reset dp");
      chk(32'(upd_pend),  32'h0, "reset pend");

      // Scan: first frame shows the reset value, 1234 appears after the boundary.
      rst_n = 1'b1;
      run_frame(16'h0000, 0, 0, 16'h1234, "f0");
      run_frame(16'h1234, -1, 0, 16'h0000, "f1");

      // Tear-free: update during slot 1 leaves digits 2,3 on the old value.
      run_frame(16'h1234, 1, 0, 16'h5678, "f2");
      run_frame(16'h5678, 0, 0, 16'h0005, "f3");

      // Leading-zero blanking and out-of-range digits.
      lzb_en = 1'b1;
      run_frame(16'hFFF5, 0, 0, 16'h0000, "f4");
      run_frame(16'hFFF0, 0, 0, 16'h0005, "f5");
      lzb_en = 1'b0;
      run_frame(16'h0005, 0, 0, 16'h0C05, "f6");
      lzb_en = 1'b1;

      // Update on the wrap cycle goes straight to the next frame.
      run_frame(16'hFF05, 3, SCAN_DIV - 1, 16'h1234, "f7");

      // Two updates before the boundary: only the last is shown.
      run_slot(0, 4'b1110, 4'h4, 1'b1, 3, 16'h1111, "f8 d0");
      run_slot(0, 4'b1101, 4'h3, 1'b1, -1, 16'h0000, "f8 d1");
      run_slot(0, 4'b1011, 4'h2, 1'b0, 5, 16'h0987, "f8 d2");
      chk(32'(upd_pend), 32'h1, "f8 pend before boundary");
      run_slot(0, 4'b0111, 4'h1, 1'b1, -1, 16'h0000, "f8 d3");
      chk(32'(upd_pend), 32'h0, "f8 pend after boundary");
      run_frame(16'hF987, -1, 0, 16'h0000, "f9");

      // Reset mid-slot with an update pending.
      run_slot(0, 4'b1110, 4'h7, 1'b1, 0, 16'h2222, "f10 d0");
      chk(32'(upd_pend), 32'h1, "f10 pend");
      repeat (4) tick();
      chk(32'(digit_sel), 32'hD, "pre-reset sel lit");
      #2 rst_n = 1'b0;
      #1;
      chk(32'(num),       32'hF, "async reset num");
      chk(32'(digit_sel), 32'hF, "async reset sel");
      chk(32'(dp),        32'h1, "async reset dp");
      chk(32'(upd_pend),  32'h0, "async reset pend");
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(16'hFFF0, -1, 0, 16'h0000, "r0");
      run_frame(16'hFFF0, -1, 0, 16'h0000, "r1");

`ifdef SEG_SCAN_BLINK_EN
      // Phase is 1 for output cycles 65..128 after release, then scanning resumes.
      blink = 1'b1;
      run_dark(BLINK_DIV, "blink dark");
      run_frame(16'hFFF0, -1, 0, 16'h0000, "blink on0");
      run_frame(16'hFFF0, -1, 0, 16'h0000, "blink on1");
      blink = 1'b0;
      run_frame(16'hFFF0, -1, 0, 16'h0000, "blink off");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
